mac_frame_serializer: RTL



---
 rtl/mac_frame_serializer_if.sv | 29 ++
 rtl/mac_frame_serializer.sv | 105 ++++++++++
 2 files changed

// File: rtl/mac_frame_serializer_if.sv
// Stream bundle between the MAC array, the frame serializer and the result path.
// The serializer sits on the slave modport; the producer/consumer side uses master.
interface mac_frame_serializer_if #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4
);
    localparam int IDXW = $clog2(CHANNELS);

    logic [WIDTH*CHANNELS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   out_data;
    logic [IDXW-1:0]           out_chan;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic                      overrun;
    logic [7:0]                drop_count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_last, out_valid, overrun, drop_count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_last, out_valid, overrun, drop_count
    );
endinterface

// File: rtl/mac_frame_serializer.sv
// Parallel-to-serial buffer: latches one frame of CHANNELS signed MAC results
// and streams them out one per beat with channel index and end-of-frame flag.
// Frames arriving while busy are dropped and counted, since the MAC array
// cannot be stalled.
module mac_frame_serializer #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4,
    parameter int REVERSE  = 0
) (
    input logic                   clk,
    input logic                   reset,
    mac_frame_serializer_if.slave bus
);
    localparam int IDXW = $clog2(CHANNELS);
    localparam logic [IDXW-1:0] LAST_BEAT = IDXW'(CHANNELS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_n;
    logic [IDXW-1:0]         beat, beat_n;
    logic signed [WIDTH-1:0] data_n;
    logic [IDXW-1:0]         chan_n;
    logic                    last_n;
    logic signed [WIDTH-1:0] frame_in [CHANNELS];
    logic signed [WIDTH-1:0] shadow   [CHANNELS];
    logic                    capture, xfer, drop, last_beat;
    logic [IDXW-1:0]         beat_inc;

    // Maps a beat number onto the channel emitted on that beat.
    function automatic logic [IDXW-1:0] chan_of(input logic [IDXW-1:0] b);
        chan_of = (REVERSE != 0) ? LAST_BEAT - b : b;
    endfunction

    // Split the packed input frame into per-channel words.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
        assign frame_in[c] = bus.in_data[c*WIDTH +: WIDTH];
    end

    assign last_beat    = (beat == LAST_BEAT);
    assign beat_inc     = beat + IDXW'(1);
    assign bus.out_valid = (state == SEND);
    // Accept a new frame when empty, or when the final beat leaves this cycle.
    assign bus.in_ready = (state == IDLE) || (bus.out_ready && last_beat);
    assign capture      = bus.in_valid && bus.in_ready;
    assign drop         = bus.in_valid && !bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;

    // Next state and next output beat; a capture takes priority so a frame
    // arriving on the last beat follows with no bubble.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        data_n  = bus.out_data;
        chan_n  = bus.out_chan;
        last_n  = bus.out_last;
        if (capture) begin
            state_n = SEND;
            beat_n  = '0;
            chan_n  = chan_of('0);
            data_n  = frame_in[chan_of('0)];
            last_n  = 1'b0;
        end else if (xfer) begin
            if (last_beat) begin
                state_n = IDLE;
            end else begin
                beat_n = beat_inc;
                chan_n = chan_of(beat_inc);
                data_n = shadow[chan_of(beat_inc)];
                last_n = (beat_inc == LAST_BEAT);
            end
        end
    end

    // State, beat counter, output register and overrun bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            beat           <= '0;
            bus.out_data   <= '0;
            bus.out_chan   <= '0;
            bus.out_last   <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            state        <= state_n;
            beat         <= beat_n;
            bus.out_data <= data_n;
            bus.out_chan <= chan_n;
            bus.out_last <= last_n;
            if (drop) begin
                bus.overrun <= 1'b1;
                if (bus.drop_count != 8'hff)
                    bus.drop_count <= bus.drop_count + 8'd1;
            end
        end
    end

    // Shadow buffer only changes on an accepted frame; drops leave it alone.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int c = 0; c < CHANNELS; c++)
                shadow[c] <= frame_in[c];
        end
    end
endmodule
